// File: rtl/brcomp_pkg.sv
// Shared definitions for the iterative branch comparator and its users.
package brcomp_pkg;

  // Default operand width and per-cycle chunk width.
  localparam int XLEN_DEF  = 32;
  localparam int CHUNK_DEF = 8;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/brcomp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module brcomp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/brcomp_iter.sv
// Multi-cycle branch comparator: walks the operands MSB chunk first and
// stops at the first chunk that differs.
module brcomp_iter
  import brcomp_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int CHUNK  = CHUNK_DEF,
  localparam int NCHUNK = (CHUNK > 0) ? (XLEN / CHUNK) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          rs1_i,
  input  logic [XLEN-1:0]          rs2_i,
  input  logic                     br_unsign,
  output logic                     valid_o,
  output logic                     br_less_o,
  output logic                     br_equal_o,
  output logic                     busy_o,
  output logic [$clog2(NCHUNK):0]  chunks_o
);

  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CNTW = $clog2(NCHUNK) + 1;
  localparam logic [XLEN-1:0] SIGN_MSK = XLEN'(1) << (XLEN - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("brcomp_iter: CHUNK must be at least 1");
  end else if ((XLEN % CHUNK) != 0) begin : g_bad_split
    $error("brcomp_iter: XLEN must be a multiple of CHUNK");
  end

  state_e            r_state;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [IDXW-1:0]   r_idx;
  logic [CNTW-1:0]   r_cnt;
  logic              r_less;
  logic              r_equal;
  logic [CNTW-1:0]   r_chunks;

  logic [XLEN-1:0]   w_flip;
  logic [CHUNK-1:0]  w_ca;
  logic [CHUNK-1:0]  w_cb;
  logic              w_lt;
  logic              w_eq;

  // Signed compare becomes unsigned once the sign bits are inverted; this
  // is folded into the operand latch so only the top chunk is affected.
  assign w_flip = br_unsign ? '0 : SIGN_MSK;

  // Select the chunk currently under examination.
  always_comb begin
    w_ca = r_a[int'(r_idx) * CHUNK +: CHUNK];
    w_cb = r_b[int'(r_idx) * CHUNK +: CHUNK];
  end

  brcomp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (w_ca),
    .b  (w_cb),
    .lt (w_lt),
    .eq (w_eq)
  );

  // Controller: accept, walk chunks with early exit, then pulse done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_less   <= 1'b0;
      r_equal  <= 1'b0;
      r_chunks <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_a     <= rs1_i ^ w_flip;
            r_b     <= rs2_i ^ w_flip;
            r_idx   <= IDXW'(NCHUNK - 1);
            r_cnt   <= '0;
            r_state <= CMP;
          end
        end
        CMP: begin
          r_cnt <= r_cnt + CNTW'(1);
          if (!w_eq) begin
            r_less   <= w_lt;
            r_equal  <= 1'b0;
            r_chunks <= r_cnt + CNTW'(1);
            r_state  <= DONE;
          end else if (r_idx == '0) begin
            r_less   <= 1'b0;
            r_equal  <= 1'b1;
            r_chunks <= CNTW'(NCHUNK);
            r_state  <= DONE;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o    = (r_state == IDLE);
  assign busy_o     = (r_state != IDLE);
  assign valid_o    = (r_state == DONE);
  assign br_less_o  = r_less;
  assign br_equal_o = r_equal;
  assign chunks_o   = r_chunks;

endmodule

// File: tb/tb_brcomp_iter.sv
// Directed self-checking bench for brcomp_iter (32/8 plus 64/16 and 64/64).
module tb_brcomp_iter;

  logic        clk = 1'b0;
  logic        rst_n;

  // 32-bit, 8-bit chunk instance
  logic        valid;
  logic [31:0] rs1, rs2;
  logic        uns;
  logic        ready, vld_o, less, equal, busy;
  logic [2:0]  chunks;

  // 64-bit instances sharing stimulus
  logic        valid64;
  logic [63:0] a64, b64;
  logic        uns64;
  logic        rdy16, vo16, l16, e16, bz16;
  logic [2:0]  c16;
  logic        rdy64, vo64, l64, e64, bz64;
  logic [0:0]  c64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  brcomp_iter #(.XLEN(32), .CHUNK(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
    .rs1_i(rs1), .rs2_i(rs2), .br_unsign(uns), .valid_o(vld_o),
    .br_less_o(less), .br_equal_o(equal), .busy_o(busy), .chunks_o(chunks)
  );

  brcomp_iter #(.XLEN(64), .CHUNK(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid64), .ready_o(rdy16),
    .rs1_i(a64), .rs2_i(b64), .br_unsign(uns64), .valid_o(vo16),
    .br_less_o(l16), .br_equal_o(e16), .busy_o(bz16), .chunks_o(c16)
  );

  brcomp_iter #(.XLEN(64), .CHUNK(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid64), .ready_o(rdy64),
    .rs1_i(a64), .rs2_i(b64), .br_unsign(uns64), .valid_o(vo64),
    .br_less_o(l64), .br_equal_o(e64), .busy_o(bz64), .chunks_o(c64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on the 32-bit instance; operands are scrambled right after
  // the accept edge so any late sampling shows up as a wrong result.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic u,
                       input int k, input logic exp_lt, input logic exp_eq,
                       input string tag);
    int edges;
    @(negedge clk);
    check({tag, "_ready"}, ready, 1'b1);
    valid = 1'b1; rs1 = a; rs2 = b; uns = u;
    @(posedge clk);
    #1;
    valid = 1'b0; rs1 = ~a; rs2 = ~b; uns = ~u;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!vld_o && edges < 20);
    check({tag, "_lat"}, 64'(edges), 64'(k));
    check({tag, "_less"}, less, exp_lt);
    check({tag, "_equal"}, equal, exp_eq);
    check({tag, "_chunks"}, chunks, 64'(k));
  endtask

  // One request applied to both 64-bit instances at once.
  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic u,
                       input int k16, input logic exp_lt, input logic exp_eq,
                       input string tag);
    int g16, g64;
    g16 = 0; g64 = 0;
    @(negedge clk);
    valid64 = 1'b1; a64 = a; b64 = b; uns64 = u;
    @(posedge clk);
    #1;
    valid64 = 1'b0; a64 = ~a; b64 = ~b;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (vo16 && g16 == 0) g16 = i;
      if (vo64 && g64 == 0) g64 = i;
    end
    check({tag, "_lat16"}, 64'(g16), 64'(k16));
    check({tag, "_lat64"}, 64'(g64), 64'd1);
    check({tag, "_less16"}, l16, exp_lt);
    check({tag, "_less64"}, l64, exp_lt);
    check({tag, "_eq16"}, e16, exp_eq);
    check({tag, "_eq64"}, e64, exp_eq);
    check({tag, "_chunks16"}, c16, 64'(k16));
    check({tag, "_chunks64"}, c64, 64'd1);
  endtask

  initial begin
    int saw;
    rst_n = 1'b0; valid = 1'b0; rs1 = '0; rs2 = '0; uns = 1'b1;
    valid64 = 1'b0; a64 = '0; b64 = '0; uns64 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", vld_o, 1'b0);
    check("rst_less", less, 1'b0);
    check("rst_equal", equal, 1'b0);
    check("rst_chunks", chunks, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ready, 1'b1);
    rst_n = 1'b1;

    run32(32'h12345678, 32'h12345678, 1'b1, 4, 1'b0, 1'b1, "eq_u");
    run32(32'hFFFFFFFF, 32'h00000001, 1'b1, 1, 1'b0, 1'b0, "ff_u");
    run32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1, 1'b1, 1'b0, "ff_s");
    run32(32'h12345678, 32'h12345679, 1'b0, 4, 1'b1, 1'b0, "lsb_s");
    run32(32'h11111111, 32'h22222222, 1'b1, 1, 1'b1, 1'b0, "one_two_u");
    run32(32'hAAAAAAAA, 32'h55555555, 1'b0, 1, 1'b1, 1'b0, "aa55_s");
    run32(32'hAAAAAAAA, 32'h55555555, 1'b1, 1, 1'b0, 1'b0, "aa55_u");
    run32(32'h12345678, 32'h12005678, 1'b1, 2, 1'b0, 1'b0, "second_u");

    // Back-to-back with valid held high and operands changed mid-compare
    @(negedge clk);
    valid = 1'b1; rs1 = 32'hCAFEBABE; rs2 = 32'hCAFEBABE; uns = 1'b1;
    @(posedge clk);
    #1;
    rs1 = 32'h00000000; rs2 = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("b2b_ready_cmp", ready, 1'b0);
      check("b2b_busy_cmp", busy, 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    check("b2b_done_valid", vld_o, 1'b1);
    check("b2b_done_ready", ready, 1'b0);
    check("b2b_first_equal", equal, 1'b1);
    check("b2b_first_chunks", chunks, 3'd4);
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_ready", ready, 1'b1);
    check("b2b_idle_valid", vld_o, 1'b0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    check("b2b_second_busy", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("b2b_second_valid", vld_o, 1'b1);
    check("b2b_second_less", less, 1'b1);
    check("b2b_second_equal", equal, 1'b0);
    check("b2b_second_chunks", chunks, 3'd1);
    @(negedge clk);
    check("hold_valid", vld_o, 1'b0);
    check("hold_less", less, 1'b1);
    check("hold_chunks", chunks, 3'd1);

    // Reset in the middle of an equal compare
    @(negedge clk);
    valid = 1'b1; rs1 = 32'h12345678; rs2 = 32'h12345678; uns = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", vld_o, 1'b0);
    check("midrst_less", less, 1'b0);
    check("midrst_equal", equal, 1'b0);
    check("midrst_chunks", chunks, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (vld_o) saw = 1;
    end
    check("midrst_no_valid", 64'(saw), 64'd0);
    run32(32'h0000FFFF, 32'h0000FFFF, 1'b0, 4, 1'b0, 1'b1, "after_rst");

    // Wider configurations
    run64(64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b1, 4, 1'b0, 1'b1, "w_eq");
    run64(64'h8000000000000000, 64'h0000000000000000, 1'b0, 1, 1'b1, 1'b0, "w_neg");
    run64(64'h0000000000000001, 64'h0000000000000000, 1'b1, 4, 1'b0, 1'b0, "w_lsb");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/brcomp_iter.md
Name: brcomp_iter

Overview:
- Parametrised, multi-cycle successor to the single-cycle branch comparator.
- Compares two XLEN-bit operands, CHUNK bits per cycle, starting at the MSB chunk. Terminates early on the first differing chunk.
- Produces br_less / br_equal in signed or unsigned mode behind a valid/ready handshake.
- Used in area-constrained core variants and for wide (64/128-bit) compare units.

Parameters:
XLEN, 32, operand width in bits
CHUNK, 8, bits compared per cycle; XLEN % CHUNK must be 0 and CHUNK >= 1 (elaboration error otherwise)
NCHUNK, XLEN/CHUNK, derived localparam, number of chunks

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  request valid
ready_o  out  1  block can accept a request
rs1_i  in  XLEN  operand A
rs2_i  in  XLEN  operand B
br_unsign  in  1  1 = unsigned compare, 0 = signed (two's complement)
valid_o  out  1  one-cycle pulse: result valid
br_less_o  out  1  rs1 < rs2 under the selected mode
br_equal_o  out  1  rs1 == rs2
busy_o  out  1  request in progress (state != IDLE)
chunks_o  out  $clog2(NCHUNK)+1  number of chunks examined for the last result

Behaviour:
- Reset (asynchronous, rst_ni low), effective immediately and from any state:
  - state=IDLE, valid_o=0, br_less_o=0, br_equal_o=0, chunks_o=0, busy_o=0.
  - Internal operand registers and idx cleared.
  - A reset mid-compare discards the request; no valid_o is produced for it.
- States:
  - IDLE:
    - ready_o=1.
    - On valid_i=1 at a rising edge: latch rs1_i, rs2_i and br_unsign; set idx=NCHUNK-1 and cnt=0; go to CMP.
  - CMP:
    - ready_o=0.
    - Each edge compares chunk idx, i.e. bits [idx*CHUNK +: CHUNK] of the latched operands, and increments cnt.
    - If the chunks differ: br_less_o = (chunkA < chunkB) unsigned; br_equal_o=0; chunks_o=cnt+1; go to DONE.
    - Else if idx==0: br_less_o=0; br_equal_o=1; chunks_o=NCHUNK; go to DONE.
    - Otherwise idx=idx-1; stay in CMP.
  - DONE:
    - valid_o=1 and ready_o=0 for exactly one cycle, then go to IDLE.
- Signed mode: invert bit XLEN-1 of both latched operands before comparing. This applies to the top chunk only; the comparison is then unsigned on every chunk.
- Latency:
  - With k = chunks examined (1..NCHUNK), valid_o is high in the cycle following the k-th edge after the accept edge.
  - Throughput is one request per k+2 cycles (IDLE accept, k CMP cycles, DONE).
- Result hold: br_less_o, br_equal_o and chunks_o are registered and hold their values until the next completion. Between completions they are not cleared.
- Input changes: rs1_i, rs2_i and br_unsign are ignored outside the accept edge. Changing them during CMP has no effect.
- valid_i asserted outside IDLE is ignored; the requester must hold it until ready_o.
- Invariant: br_less_o and br_equal_o are never both 1.
- CHUNK == XLEN is legal: k is always 1 and latency is 1 edge plus DONE.

Decomposition:
- Shared package brcomp_pkg:
  - state encoding localparams IDLE=2'd0, CMP=2'd1, DONE=2'd2;
  - the default XLEN and CHUNK constants, shared with alu/brcomp users.
- One natural combinational sub-module, brcomp_chunk, parametrised by CHUNK:
  - inputs: a, b;
  - outputs: lt, eq;
  - instantiated once and muxed by idx.
- The FSM, idx/cnt counters and result registers live in brcomp_iter.

Test Plan (XLEN=32, CHUNK=8):
- rs1=rs2=0x12345678, unsigned:
  - valid_o arrives 4 edges after accept;
  - less=0, equal=1, chunks_o=4.
- rs1=0xFFFFFFFF, rs2=0x00000001:
  - unsigned → less=0, equal=0, chunks_o=1 (early exit after 1 edge);
  - signed → less=1, equal=0, chunks_o=1.
- rs1=0x12345678, rs2=0x12345679, signed:
  - less=1, equal=0, chunks_o=4.
- rs1=0x11111111, rs2=0x22222222, unsigned → less=1, chunks_o=1.
- rs1=0xAAAAAAAA, rs2=0x55555555, signed → less=1; unsigned → less=0.
- Back-to-back valid_i held high:
  - ready_o low during CMP/DONE;
  - second request accepted the cycle after DONE;
  - operand changes mid-CMP do not affect the result.
- Reset:
  - assert rst_ni=0 during CMP (cycle 2 of an equal compare) → outputs are 0 immediately;
  - no valid_o pulse after release;
  - the next request completes normally.
- Parameter sweep (directed): XLEN=64, CHUNK=16 and CHUNK=XLEN:
  - equal operands give chunks_o=4 and 1 respectively.
